direct_mapped_cache: RTL and testbench

Direct-mapped, read-allocate cache sitting between the cache access controller (upstream, drives `cache_read`/`address`, consumes `cache_ready`/`hit_count`) and main memory (downstream, block-wide fetch handshake). Each access gets exactly one `cache_ready` pulse. Hits are served from internal tag/data arrays; misses fetch a full block, fill the line, then respond. A running 14-bit hit counter feeds the controller's hit-rate computation.

---
 rtl/direct_mapped_cache.sv | 158 +++++++++++++++
 tb/tb_direct_mapped_cache.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/direct_mapped_cache.sv
// Direct-mapped, read-allocate cache: 256 lines of 4 words, refilled a whole block at a time.
// Every request gets exactly one cache_ready pulse; hits are tallied in a wrapping 14-bit counter.
module direct_mapped_cache #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cache_read_i,
  input  logic                              cache_write_i,
  input  logic [ADDR_W-1:0]                 address_i,
  output logic                              cache_ready_o,
  output logic [DATA_W-1:0]                 cache_rdata_o,
  output logic [13:0]                       hit_count_o,
  output logic                              mem_read_o,
  output logic [ADDR_W-OFFSET_W-1:0]        mem_addr_o,
  input  logic                              mem_ready_i,
  input  logic [(DATA_W<<OFFSET_W)-1:0]     mem_rdata_i
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int BLK_W = DATA_W << OFFSET_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMPARE  = 2'd1,
    MEM_WAIT = 2'd2,
    RESPOND  = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic                        ready_q, ready_d;
  logic [DATA_W-1:0]           rdata_q, rdata_d;
  logic [13:0]                 hit_cnt_q, hit_cnt_d;
  logic                        mem_read_q, mem_read_d;
  logic [ADDR_W-OFFSET_W-1:0]  mem_addr_q, mem_addr_d;

  logic [LINES-1:0]            valid_q;
  logic [TAG_W-1:0]            tag_mem [LINES];
  logic [BLK_W-1:0]            data_mem [LINES];

  logic [TAG_W-1:0]            tag_s;
  logic [INDEX_W-1:0]          idx_s;
  logic [OFFSET_W-1:0]         off_s;
  logic [BLK_W-1:0]            line_s;
  logic                        hit_s;
  logic                        fill_s;

  function automatic logic [DATA_W-1:0] word_sel(input logic [BLK_W-1:0] blk,
                                                 input logic [OFFSET_W-1:0] off);
    return blk[32'(off)*DATA_W +: DATA_W];
  endfunction

  // The latched request address, not the live input, drives every lookup after IDLE.
  assign tag_s  = addr_q[ADDR_W-1 -: TAG_W];
  assign idx_s  = addr_q[OFFSET_W +: INDEX_W];
  assign off_s  = addr_q[OFFSET_W-1:0];
  assign line_s = data_mem[idx_s];
  assign hit_s  = valid_q[idx_s] && (tag_mem[idx_s] == tag_s);
  assign fill_s = (state_q == MEM_WAIT) && mem_ready_i;

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= {ADDR_W{1'b0}};
      ready_q    <= 1'b0;
      rdata_q    <= {DATA_W{1'b0}};
      hit_cnt_q  <= 14'd0;
      mem_read_q <= 1'b0;
      mem_addr_q <= {(ADDR_W-OFFSET_W){1'b0}};
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      hit_cnt_q  <= hit_cnt_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ready_d    = 1'b0;
    rdata_d    = rdata_q;
    hit_cnt_d  = hit_cnt_q;
    mem_read_d = mem_read_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (cache_read_i) begin
          addr_d  = address_i;
          state_d = COMPARE;
        end else if (cache_write_i) begin
          rdata_d = {DATA_W{1'b0}};
          ready_d = 1'b1;
          state_d = RESPOND;
        end else begin
          state_d = IDLE;
        end
      end
      COMPARE: begin
        if (hit_s) begin
          hit_cnt_d = hit_cnt_q + 14'd1;
          rdata_d   = word_sel(line_s, off_s);
          ready_d   = 1'b1;
          state_d   = RESPOND;
        end else begin
          mem_read_d = 1'b1;
          mem_addr_d = addr_q[ADDR_W-1:OFFSET_W];
          state_d    = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_ready_i) begin
          rdata_d    = word_sel(mem_rdata_i, off_s);
          mem_read_d = 1'b0;
          ready_d    = 1'b1;
          state_d    = RESPOND;
        end else begin
          state_d = MEM_WAIT;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Valid bits are the only array state cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= {LINES{1'b0}};
    end else if (fill_s) begin
      valid_q[idx_s] <= 1'b1;
    end
  end

  // Tag and data storage, written only on a completed refill
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_mem[idx_s]  <= tag_s;
      data_mem[idx_s] <= mem_rdata_i;
    end
  end

  assign cache_ready_o = ready_q;
  assign cache_rdata_o = rdata_q;
  assign hit_count_o   = hit_cnt_q;
  assign mem_read_o    = mem_read_q;
  assign mem_addr_o    = mem_addr_q;

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Bench for direct_mapped_cache: directed vector table, hand-written reset/write sequences,
// and random plus sweep traffic checked against a residency-map reference model.
module tb_direct_mapped_cache;
  logic         clk = 1'b0;
  logic         rst;
  logic         cache_read_i, cache_write_i, mem_ready_i;
  logic [14:0]  address_i;
  logic [127:0] mem_rdata_i;
  logic         cache_ready_o, mem_read_o;
  logic [31:0]  cache_rdata_o;
  logic [13:0]  hit_count_o;
  logic [12:0]  mem_addr_o;

  int checks = 0;
  int failures = 0;

  // Reference model: which block address is resident in each line, and the hit tally.
  int res_blk [256];
  int m_hc;

  typedef struct {
    bit          do_rst;
    logic [14:0] addr;
    int          lat;
    int          exp_fetch;
    int          exp_hc;
  } vec_t;
  vec_t vecs [12];

  always #5 clk = ~clk;

  direct_mapped_cache dut (
    .clk(clk), .rst(rst),
    .cache_read_i(cache_read_i), .cache_write_i(cache_write_i), .address_i(address_i),
    .cache_ready_o(cache_ready_o), .cache_rdata_o(cache_rdata_o), .hit_count_o(hit_count_o),
    .mem_read_o(mem_read_o), .mem_addr_o(mem_addr_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Backing memory contents: every word is unique to its block and position.
  function automatic logic [127:0] blk_data(input logic [12:0] blk);
    logic [127:0] b;
    for (int w = 0; w < 4; w++) b[w*32 +: 32] = {blk, w[1:0], 17'h0A5C3};
    return b;
  endfunction

  function automatic logic [31:0] exp_word(input logic [14:0] a);
    logic [127:0] b;
    b = blk_data(a[14:2]);
    return b[int'(a[1:0])*32 +: 32];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) res_blk[i] = -1;
    m_hc = 0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; cache_read_i = 1'b0; cache_write_i = 1'b0; mem_ready_i = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Issue one read and act as main memory with the given latency; bounded wait for the response.
  task automatic do_read(input logic [14:0] a, input int lat, output bit got,
                         output logic [31:0] rd, output int fetches, output bit addr_ok);
    int wc;
    got = 1'b0; rd = 32'd0; fetches = 0; addr_ok = 1'b1; wc = 0;
    @(negedge clk); cache_read_i = 1'b1; address_i = a;
    @(negedge clk); cache_read_i = 1'b0; address_i = 15'($urandom);
    for (int c = 0; c < 40; c++) begin
      mem_ready_i = 1'b0;
      if (cache_ready_o) begin
        got = 1'b1; rd = cache_rdata_o;
        break;
      end
      if (mem_read_o) begin
        if (wc >= lat) begin
          mem_ready_i = 1'b1; mem_rdata_i = blk_data(mem_addr_o);
          fetches++; wc = 0;
          if (mem_addr_o !== a[14:2]) addr_ok = 1'b0;
        end else begin
          wc++;
        end
      end
      @(negedge clk);
    end
    mem_ready_i = 1'b0;
  endtask

  task automatic check_read(input logic [14:0] a, input int lat, input string nm,
                            output bit got, output int f);
    bit aok, hit;
    logic [31:0] rd;
    logic [12:0] blk;
    blk = a[14:2];
    hit = (res_blk[int'(blk[7:0])] == int'(blk));
    do_read(a, lat, got, rd, f, aok);
    if (hit) m_hc = (m_hc + 1) % 16384;
    else res_blk[int'(blk[7:0])] = int'(blk);
    check({nm, " ready"}, got, 1'b1);
    check({nm, " rdata"}, rd, exp_word(a));
    check({nm, " fetches"}, f, hit ? 0 : 1);
    check({nm, " hit_count"}, hit_count_o, m_hc);
    check({nm, " mem_addr"}, aok, 1'b1);
  endtask

  initial begin
    bit got, aok;
    logic [31:0] rd;
    int f, pulses, tot_pulses, tot_fetch;
    logic [31:0] wr_rdata;

    vecs[0]  = '{1'b1, 15'd1024,  2, 1, 0};
    vecs[1]  = '{1'b0, 15'd1025,  2, 0, 1};
    vecs[2]  = '{1'b0, 15'd1026,  2, 0, 2};
    vecs[3]  = '{1'b0, 15'd1027,  2, 0, 3};
    vecs[4]  = '{1'b1, 15'd1024,  1, 1, 0};
    vecs[5]  = '{1'b0, 15'd2048,  3, 1, 0};
    vecs[6]  = '{1'b0, 15'd1024,  0, 1, 0};
    vecs[7]  = '{1'b0, 15'd1025,  0, 0, 1};
    vecs[8]  = '{1'b1, 15'd0,     0, 1, 0};
    vecs[9]  = '{1'b0, 15'd3,     4, 0, 1};
    vecs[10] = '{1'b0, 15'd32767, 5, 1, 1};
    vecs[11] = '{1'b0, 15'd32764, 0, 0, 2};

    rst = 1'b1; cache_read_i = 1'b0; cache_write_i = 1'b0; mem_ready_i = 1'b0;
    address_i = 15'd0; mem_rdata_i = 128'd0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst cache_ready", cache_ready_o, 1'b0);
    check("rst cache_rdata", cache_rdata_o, 32'd0);
    check("rst hit_count", hit_count_o, 14'd0);
    check("rst mem_read", mem_read_o, 1'b0);
    check("rst mem_addr", mem_addr_o, 13'd0);
    rst = 1'b0;

    // First read misses; abort it with reset in MEM_WAIT, then feed a late mem_ready
    @(negedge clk); cache_read_i = 1'b1; address_i = 15'd1024;
    @(negedge clk); cache_read_i = 1'b0;
    @(negedge clk);
    check("miss mem_read", mem_read_o, 1'b1);
    check("miss mem_addr", mem_addr_o, 13'd256);
    rst = 1'b1;
    #1;
    check("abort mem_read", mem_read_o, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk); mem_ready_i = 1'b1; mem_rdata_i = blk_data(13'd256);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready_i = 1'b0;
      if (cache_ready_o || mem_read_o) pulses++;
    end
    check("late mem_ready activity", pulses, 0);
    check_read(15'd1024, 1, "reread", got, f);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_rst) do_reset(2);
      do_read(vecs[i].addr, vecs[i].lat, got, rd, f, aok);
      check($sformatf("vec%0d ready", i), got, 1'b1);
      check($sformatf("vec%0d rdata", i), rd, exp_word(vecs[i].addr));
      check($sformatf("vec%0d fetches", i), f, vecs[i].exp_fetch);
      check($sformatf("vec%0d hit_count", i), hit_count_o, vecs[i].exp_hc);
      check($sformatf("vec%0d mem_addr", i), aok, 1'b1);
    end

    // Write-only request and stray mem_ready in IDLE
    do_reset(2);
    check_read(15'd1030, 1, "w_pre0", got, f);
    check_read(15'd1031, 0, "w_pre1", got, f);
    @(negedge clk); cache_write_i = 1'b1; address_i = 15'd1028;
    @(negedge clk); cache_write_i = 1'b0;
    pulses = 0; wr_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      if (cache_ready_o) begin pulses++; wr_rdata = cache_rdata_o; end
      @(negedge clk);
    end
    check("write pulses", pulses, 1);
    check("write rdata", wr_rdata, 32'd0);
    check("write hit_count", hit_count_o, m_hc);
    mem_ready_i = 1'b1; mem_rdata_i = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
    @(negedge clk); mem_ready_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      if (cache_ready_o || mem_read_o) pulses++;
      @(negedge clk);
    end
    check("idle mem_ready activity", pulses, 0);
    check_read(15'd1029, 0, "w_post", got, f);

    // Random traffic over a few conflicting tags and a handful of lines
    do_reset(2);
    for (int i = 0; i < 300; i++) begin
      check_read({5'($urandom_range(0, 3)), 8'($urandom_range(0, 7)), 2'($urandom)},
                 $urandom_range(0, 5), $sformatf("rnd%0d", i), got, f);
    end

    // Sequential sweep as driven by the controller
    do_reset(2);
    tot_pulses = 0; tot_fetch = 0;
    for (int i = 0; i < 8192; i++) begin
      check_read(15'(1024 + i), $urandom_range(0, 5), "sweep", got, f);
      tot_pulses += int'(got);
      tot_fetch  += f;
    end
    check("sweep pulses", tot_pulses, 8192);
    check("sweep fetches", tot_fetch, 2048);
    check("sweep hit_count", hit_count_o, 14'd6144);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
